// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one sram-like memory port between the instruction fetch requester
// (pre-IF) and the data requester (EXE/MEM). Accepted transactions are
// recorded in an owner FIFO, and each in-order response is routed back to
// the requester that issued it. A flush from WB marks every instruction entry
// in the FIFO as dropped, so its response is consumed silently. Data responses
// are never dropped.
//
// Optional build macro:
//   ARB_RR_EN - the unlocked grant alternates between requesters (round-robin)
//               instead of giving data fixed priority over inst.
//
// Ports:
//   clk, reset                    clock, async active-high reset
//   inst_req/inst_addr            fetch request (held until inst_addr_ok)
//   inst_addr_ok                  fetch accepted this cycle
//   inst_data_ok/inst_rdata       fetch response
//   data_req/wr/size/wstrb/addr/wdata   data request (held until data_addr_ok)
//   data_addr_ok                  data request accepted this cycle
//   data_data_ok/data_rdata       data response (store ack or load data)
//   mem_req/wr/size/wstrb/addr/wdata    downstream request
//   mem_addr_ok                   downstream accept
//   mem_data_ok/mem_rdata         downstream in-order response
//   flush                         one-cycle pulse, WB exception or ertn
//   busy                          owner FIFO non-empty
//
// Handshake: a request transfers on a cycle where req and addr_ok are both
// high; the requester holds req and its fields stable until then. Responses
// are single-cycle data_ok pulses, one per accepted transaction, in order.
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int OUTSTANDING = 4,
  parameter int AW          = 32,
  parameter int DW          = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          inst_req,
  input  logic [AW-1:0] inst_addr,
  output logic          inst_addr_ok,
  output logic          inst_data_ok,
  output logic [DW-1:0] inst_rdata,
  input  logic          data_req,
  input  logic          data_wr,
  input  logic [1:0]    data_size,
  input  logic [3:0]    data_wstrb,
  input  logic [AW-1:0] data_addr,
  input  logic [DW-1:0] data_wdata,
  output logic          data_addr_ok,
  output logic          data_data_ok,
  output logic [DW-1:0] data_rdata,
  output logic          mem_req,
  output logic          mem_wr,
  output logic [1:0]    mem_size,
  output logic [3:0]    mem_wstrb,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_addr_ok,
  input  logic          mem_data_ok,
  input  logic [DW-1:0] mem_rdata,
  input  logic          flush,
  output logic          busy
);

  localparam int PW = $clog2(OUTSTANDING);
  localparam int CW = PW + 1;

  localparam logic OWN_INST = 1'b0;
  localparam logic OWN_DATA = 1'b1;

  logic [CW-1:0]          count_q, count_d;
  logic [PW-1:0]          wptr_q, wptr_d;
  logic [PW-1:0]          rptr_q, rptr_d;
  logic [OUTSTANDING-1:0] owner_q, owner_d;
  logic [OUTSTANDING-1:0] drop_q, drop_d;
  logic                   lock_valid_q, lock_valid_d;
  logic                   lock_owner_q, lock_owner_d;
`ifdef ARB_RR_EN
  // 0 = data preferred, 1 = inst preferred
  logic                   rr_q, rr_d;
`endif

  logic full;
  logic grant_vld;
  logic grant_own;
  logic accept;
  logic pop;
  logic head_own;
  logic head_drop;

  assign full = (count_q == CW'(OUTSTANDING));

  // Grant selection. Reset is folded in so no request leaks out while the
  // FIFO is being cleared.
  always_comb begin
    grant_vld = 1'b0;
    grant_own = OWN_INST;
    if (reset) begin
      grant_vld = 1'b0;
    end else if (lock_valid_q) begin
      grant_vld = 1'b1;
      grant_own = lock_owner_q;
    end else begin
`ifdef ARB_RR_EN
      if (data_req && inst_req) begin
        grant_vld = 1'b1;
        grant_own = rr_q ? OWN_INST : OWN_DATA;
      end else
`endif
      if (data_req) begin
        grant_vld = 1'b1;
        grant_own = OWN_DATA;
      end else if (inst_req) begin
        grant_vld = 1'b1;
        grant_own = OWN_INST;
      end
    end
  end

  assign mem_req = grant_vld & ~full & ((grant_own == OWN_DATA) ? data_req : inst_req);
  assign accept  = mem_req & mem_addr_ok;

  assign inst_addr_ok = accept & (grant_own == OWN_INST);
  assign data_addr_ok = accept & (grant_own == OWN_DATA);

  // Downstream fields follow the grant; fetches are always word reads.
  always_comb begin
    mem_wr    = 1'b0;
    mem_size  = 2'd0;
    mem_wstrb = 4'd0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (grant_vld) begin
      if (grant_own == OWN_DATA) begin
        mem_wr    = data_wr;
        mem_size  = data_size;
        mem_wstrb = data_wstrb;
        mem_addr  = data_addr;
        mem_wdata = data_wdata;
      end else begin
        mem_addr  = inst_addr;
        mem_size  = 2'd2;
      end
    end
  end

  // A response with an empty FIFO is a protocol error and is ignored.
  assign pop       = mem_data_ok & (count_q != '0);
  assign head_own  = owner_q[rptr_q];
  assign head_drop = drop_q[rptr_q];

  assign data_data_ok = pop & (head_own == OWN_DATA);
  assign inst_data_ok = pop & (head_own == OWN_INST) & ~head_drop;
  assign data_rdata   = data_data_ok ? mem_rdata : '0;
  assign inst_rdata   = inst_data_ok ? mem_rdata : '0;

  assign busy = (count_q != '0);

  always_comb begin
    count_d      = count_q;
    wptr_d       = wptr_q;
    rptr_d       = rptr_q;
    owner_d      = owner_q;
    drop_d       = drop_q;
    lock_valid_d = lock_valid_q;
    lock_owner_d = lock_owner_q;
`ifdef ARB_RR_EN
    rr_d         = rr_q;
`endif

    // Flush marks every inst slot. Slots outside the valid window are
    // rewritten on push before they are ever read, so marking them is harmless.
    if (flush) begin
      drop_d = drop_q | ~owner_q;
    end

    if (accept) begin
      owner_d[wptr_q] = grant_own;
      drop_d[wptr_q]  = (grant_own == OWN_INST) & flush;
      wptr_d          = wptr_q + 1'b1;
    end

    if (pop) begin
      rptr_d = rptr_q + 1'b1;
    end

    case ({accept, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // Hold the grant while downstream stalls so request fields stay stable.
    if (accept) begin
      lock_valid_d = 1'b0;
    end else if (mem_req) begin
      lock_valid_d = 1'b1;
      lock_owner_d = grant_own;
    end

`ifdef ARB_RR_EN
    if (accept) begin
      rr_d = ~rr_q;
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q      <= '0;
      wptr_q       <= '0;
      rptr_q       <= '0;
      owner_q      <= '0;
      drop_q       <= '0;
      lock_valid_q <= 1'b0;
      lock_owner_q <= 1'b0;
`ifdef ARB_RR_EN
      rr_q         <= 1'b0;
`endif
    end else begin
      count_q      <= count_d;
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      owner_q      <= owner_d;
      drop_q       <= drop_d;
      lock_valid_q <= lock_valid_d;
      lock_owner_q <= lock_owner_d;
`ifdef ARB_RR_EN
      rr_q         <= rr_d;
`endif
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single sram-like memory port between the instruction requester (pre-IF) and the data requester (EXE/MEM).
- Tracks the order of outstanding transactions in an owner FIFO and routes each in-order response back to its owner.
- On a pipeline flush from WB (exception or ertn), instruction responses already in flight are silently discarded. Data responses are never discarded.

Parameters:
- OUTSTANDING, 4, owner FIFO depth (max accepted-but-unanswered transactions); power of 2, ≥2.
- AW, 32, address width.
- DW, 32, data width.

Ports:
- clk  in  1  clock
- reset  in  1  async active-high reset
- inst_req  in  1  instruction request, held until inst_addr_ok
- inst_addr  in  AW  fetch address
- inst_addr_ok  out  1  inst request accepted this cycle
- inst_data_ok  out  1  inst response valid
- inst_rdata  out  DW  inst response data
- data_req  in  1  data request, held until data_addr_ok
- data_wr  in  1  1 = store
- data_size  in  2  0 = byte, 1 = half, 2 = word
- data_wstrb  in  4  byte strobes
- data_addr  in  AW  data address
- data_wdata  in  DW  store data
- data_addr_ok  out  1  data request accepted
- data_data_ok  out  1  data response valid (store ack or load data)
- data_rdata  out  DW  load data
- mem_req  out  1  downstream request
- mem_wr  out  1  downstream write
- mem_size  out  2  downstream size
- mem_wstrb  out  4  downstream strobes
- mem_addr  out  AW  downstream address
- mem_wdata  out  DW  downstream write data
- mem_addr_ok  in  1  downstream accept
- mem_data_ok  in  1  downstream in-order response
- mem_rdata  in  DW  downstream read data
- flush  in  1  one-cycle pulse, WB exception or ertn
- busy  out  1  FIFO non-empty

Behaviour:
- Reset is asynchronous. It clears FIFO count, read/write pointers, all drop bits, lock_valid, lock_owner and the rr pointer.
- After reset all outputs are 0.

Grant:
- If lock_valid, the grant is lock_owner.
- Otherwise the grant is data when data_req=1, else inst when inst_req=1, else none.
- mem_req = granted requester's req & (count != OUTSTANDING).
- Full FIFO forces mem_req=0 and both addr_ok=0.

Muxing:
- mem_* fields are taken from the granted requester.
- For inst grants: mem_wr=0, mem_size=2, mem_wstrb=0, mem_wdata=0.

Lock:
- When mem_req=1 and mem_addr_ok=0, register lock_valid=1 and lock_owner=grant.
- The lock guarantees downstream request fields stay stable until accepted.
- The lock is cleared on the accept cycle.

Accept (mem_req & mem_addr_ok):
- Pulse the owner's addr_ok combinationally in the same cycle.
- Push {owner, drop} at wptr.
- drop = (owner==inst) & flush.

Response (mem_data_ok):
- Pop head entry.
- If owner==data: data_data_ok=1, data_rdata=mem_rdata.
- If owner==inst and drop=0: inst_data_ok=1, inst_rdata=mem_rdata.
- If owner==inst and drop=1: no output.
- Zero-cycle latency (combinational).
- rdata outputs are 0 when their data_ok is 0.

Flush:
- Sets drop on every valid inst entry in the FIFO in the same clock edge, including the entry pushed in that cycle.
- Data entries are untouched.
- Flush does not clear the lock. Pre-IF keeps its req asserted until addr_ok, and that accepted fetch is dropped if flush coincides with it.
- Pre-IF must not count dropped responses.

Boundary conditions:
- Simultaneous push and pop: count unchanged. This holds even when full, because the pop frees a slot that cycle only at the next edge; mem_req is still gated by the registered count.
- Pop with count=0: protocol error. Ignored; no data_ok, pointers unchanged.
- Pointers wrap modulo OUTSTANDING.
- busy = (count != 0).

Optional Feature:
ARB_RR_EN:
- When defined, the unlocked grant is round-robin.
- A 1-bit rr register names the preferred requester and starts at data after reset.
- rr flips to the other requester on each accepted transaction.
- When undefined, data has fixed priority over inst, as above.

Test Plan:
1. Reset mid-operation: with 3 entries queued, assert reset -> busy=0, mem_req=0 same cycle. After release, a mem_data_ok pulse produces no data_ok.
2. Fixed priority: inst_req and data_req both 1 with data_addr=0x1c000100 and mem_addr_ok=1 -> data accepted first, mem_addr=0x1c000100. Next cycle inst_addr=0x1c000000 is accepted. Responses 0xAAAA0000 then 0x11110000 route to data then inst.
3. Lock: inst granted while mem_addr_ok=0 for 3 cycles, then data_req rises -> mem_addr stays at the inst address until accept; data is granted afterwards.
4. Full: OUTSTANDING=4, four accepts without response -> mem_req=0 and inst_addr_ok=0. One mem_data_ok -> mem_req=1 next cycle.
5. Flush: queue inst, data, inst, then pulse flush; 3 responses follow -> only data_data_ok asserts (1 pulse), inst_data_ok stays 0, busy=0 afterwards.
6. ARB_RR_EN: both requesters held continuously with mem_addr_ok=1 -> accepts alternate data, inst, data, inst.
